sam_mem_unit: RTL
=================

// Module: sam_mem_unit
// PURPOSE
//  Unified 8-bit program/data memory serving the SAM accumulator CPU control unit, plus a byte-wide program loader.
//  CPU side uses a two-access protocol on en/rw: first access latches the address, second reads or writes data.
//  Loader side writes consecutive bytes while holding the CPU in reset via cpu_hold; sits directly on the CPU's bus.
// PARAMETERS
//  AW          8      address width; memory depth = 2**AW words
//  DW          8      data width
//  PROT_LIMIT  8'h40  CPU writes to addr < PROT_LIMIT are blocked (only with MEM_PROTECT_EN)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   reset, synchronous, active-high
//  en         in   1   CPU access strobe, one cycle per access
//  rw         in   1   1 = read / address phase, 0 = write data phase
//  addr_in    in   AW  CPU address bus (PC/IReg/IAR buffer output)
//  data_in    in   DW  CPU write data (Acc buffer output)
//  data_out   out  DW  registered read data to IReg/Acc/PC muxes
//  data_valid out  1   one-cycle pulse, data_out updated this cycle
//  ld_start   in   1   enter load mode; ld_base becomes write pointer
//  ld_base    in   AW  load start address
//  ld_valid   in   1   loader byte present
//  ld_data    in   DW  loader byte
//  ld_ready   out  1   loader byte accepted when ld_valid & ld_ready
//  ld_stop    in   1   leave load mode
//  ld_wrap    out  1   sticky: pointer wrapped 2**AW-1 -> 0 during current load
//  cpu_hold   out  1   high in LOAD; drives CPU rst
//  wr_fault   out  1   one-cycle pulse: CPU write blocked or access during LOAD
// BEHAVIOUR
//  Reset: state=IDLE, data_out=0, data_valid=0, ld_ready=0, ld_wrap=0, cpu_hold=0, wr_fault=0, mar=0, ptr=0.
//  Memory array is NOT reset; contents survive rst. Reset mid-load aborts load, drops cpu_hold next cycle.
//  FSM states: IDLE, ADDR, LOAD.
//  IDLE: en&rw -> mar<=addr_in, ->ADDR. en&!rw in IDLE: ignored, wr_fault pulse, stay IDLE.
//  ADDR: waits indefinitely (idle gaps between accesses allowed, e.g. fetch tick0 -> tick2).
//   en&rw  -> data_out<=mem[mar], data_valid=1 next cycle, ->IDLE. Read latency: 1 clk after second en.
//   en&!rw -> mem[mar]<=data_in, ->IDLE; data_out unchanged, no data_valid.
//  data_out holds last read value until next read; data_valid is exactly one cycle.
//  LOAD: entered from IDLE or ADDR on ld_start (ld_start wins over en same cycle; latched mar discarded).
//   Entry: ptr<=ld_base, ld_wrap<=0, cpu_hold<=1, ld_ready<=1 from next cycle.
//   ld_valid&ld_ready -> mem[ptr]<=ld_data, ptr<=ptr+1 (mod 2**AW); ptr==2**AW-1 accept sets ld_wrap.
//   ld_stop -> IDLE next cycle, ld_ready<=0, cpu_hold<=0; byte with ld_valid in same cycle as ld_stop is written.
//   ld_start while in LOAD: reload ptr<=ld_base, clear ld_wrap, stay LOAD.
//   en during LOAD: ignored, wr_fault pulse, no memory effect.
//  ld_ready low outside LOAD; ld_valid outside LOAD ignored silently.
//  Write-before-read: read of address written on earlier cycle returns new value; no same-cycle bypass needed.
// CONFIGURATION
//  MEM_PROTECT_EN defined: CPU data-phase write with mar < PROT_LIMIT is dropped, wr_fault pulses,
//   FSM still returns to IDLE. Loader writes never protected.
//  MEM_PROTECT_EN undefined: all CPU writes performed; PROT_LIMIT unused; wr_fault only for misuse cases above.
// TESTING
//  1 rst; ld_start base=0x10; bytes 0xA1,0xA2,0xA3; ld_stop -> mem[10..12]=A1,A2,A3, cpu_hold 1 then 0, ld_wrap=0.
//  2 en rw=1 addr=0x11; 2 idle; en rw=1 -> data_valid 1 clk later, data_out=0xA2; holds after pulse.
//  3 en rw=1 addr=0x80; en rw=0 data=0x5C; read 0x80 -> data_out=0x5C; write phase gives no data_valid.
//  4 ld_start base=0xFE; bytes 01,02,03 -> mem[FE]=01,mem[FF]=02,mem[00]=03, ld_wrap=1; new ld_start clears it.
//  5 MEM_PROTECT_EN: write 0x77 to 0x20 -> wr_fault pulse, mem[20] unchanged; to 0x40 -> written. Without macro: both written.
//  6 rst asserted mid-load after 1 byte -> cpu_hold 0, ld_ready 0, state IDLE, written byte retained; en during LOAD -> wr_fault.

Source files
------------

// File: rtl/sam_mem_unit.sv
// sam_mem_unit: unified 8-bit program/data memory for the SAM accumulator CPU
// with a byte-wide program loader sharing the same array.
//   CPU side : two-access protocol on en/rw (address phase, then data phase).
//   Loader   : streams consecutive bytes from ld_base while holding the CPU
//              in reset through cpu_hold.
// Optional build macro MEM_PROTECT_EN: CPU data-phase writes to addresses
// below PROT_LIMIT are dropped and flagged on wr_fault. Loader writes are
// never protected.
module sam_mem_unit #(
    parameter int unsigned   AW         = 8,
    parameter int unsigned   DW         = 8,
    parameter logic [AW-1:0] PROT_LIMIT = AW'('h40)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          rw,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          ld_stop,
    output logic          ld_wrap,
    output logic          cpu_hold,
    output logic          wr_fault
);

    localparam int unsigned DEPTH = 1 << AW;

`ifdef MEM_PROTECT_EN
    localparam bit C_PROTECT = 1'b1;
`else
    localparam bit C_PROTECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [DW-1:0] r_mem [0:DEPTH-1];

    logic [AW-1:0] r_mar;
    logic [AW-1:0] r_ptr;
    logic [DW-1:0] r_data_out;
    logic          r_data_valid;
    logic          r_ld_ready;
    logic          r_ld_wrap;
    logic          r_cpu_hold;
    logic          r_wr_fault;

    logic [AW-1:0] w_mar_next;
    logic [AW-1:0] w_ptr_next;
    logic          w_ld_wrap_next;
    logic          w_wr_fault_next;
    logic          w_rd_en;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic          w_load_next;
    logic          w_prot_block;

    // Protection folds to constant 0 when the macro is not defined.
    assign w_prot_block = C_PROTECT && (r_mar < PROT_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, register updates and memory write port selection.
    always_comb begin
        w_state_next    = r_state;
        w_mar_next      = r_mar;
        w_ptr_next      = r_ptr;
        w_ld_wrap_next  = r_ld_wrap;
        w_wr_fault_next = 1'b0;
        w_rd_en         = 1'b0;
        w_mem_we        = 1'b0;
        w_mem_addr      = r_mar;
        w_mem_wdata     = data_in;

        case (r_state)
            S_IDLE: begin
                if (ld_start) begin
                    w_state_next   = S_LOAD;
                    w_ptr_next     = ld_base;
                    w_ld_wrap_next = 1'b0;
                end else if (en && rw) begin
                    w_mar_next   = addr_in;
                    w_state_next = S_ADDR;
                end else if (en) begin
                    // Data phase without a preceding address phase.
                    w_wr_fault_next = 1'b1;
                end
            end

            S_ADDR: begin
                if (ld_start) begin
                    // Loader takes priority; the latched address is dropped.
                    w_state_next   = S_LOAD;
                    w_ptr_next     = ld_base;
                    w_ld_wrap_next = 1'b0;
                end else if (en && rw) begin
                    w_rd_en      = 1'b1;
                    w_state_next = S_IDLE;
                end else if (en) begin
                    if (w_prot_block) begin
                        w_wr_fault_next = 1'b1;
                    end else begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = r_mar;
                        w_mem_wdata = data_in;
                    end
                    w_state_next = S_IDLE;
                end
            end

            S_LOAD: begin
                if (ld_valid && r_ld_ready) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_ptr;
                    w_mem_wdata = ld_data;
                    w_ptr_next  = r_ptr + 1'b1;
                    if (r_ptr == '1) begin
                        w_ld_wrap_next = 1'b1;
                    end
                end
                if (en) begin
                    w_wr_fault_next = 1'b1;
                end
                // A byte offered alongside ld_stop/ld_start is still written
                // at the old pointer; stop takes priority over a restart.
                if (ld_stop) begin
                    w_state_next = S_IDLE;
                end else if (ld_start) begin
                    w_ptr_next     = ld_base;
                    w_ld_wrap_next = 1'b0;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_load_next = (w_state_next == S_LOAD);
    end

    // Registered outputs and address/pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mar        <= '0;
            r_ptr        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_ld_ready   <= 1'b0;
            r_ld_wrap    <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_wr_fault   <= 1'b0;
        end else begin
            r_mar        <= w_mar_next;
            r_ptr        <= w_ptr_next;
            r_data_valid <= w_rd_en;
            r_ld_ready   <= w_load_next;
            r_ld_wrap    <= w_ld_wrap_next;
            r_cpu_hold   <= w_load_next;
            r_wr_fault   <= w_wr_fault_next;
            if (w_rd_en) begin
                r_data_out <= r_mem[r_mar];
            end
        end
    end

    // Memory array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign ld_ready   = r_ld_ready;
    assign ld_wrap    = r_ld_wrap;
    assign cpu_hold   = r_cpu_hold;
    assign wr_fault   = r_wr_fault;

endmodule
